input_poll_scheduler: RTL and testbench
=======================================

INPUT_POLL_SCHEDULER -- requirements
Module: input_poll_scheduler

Interface
REQ-001 Parameter VBLANK_LINE, default 480: first vertical-blank line of the 640x480 raster.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000: maximum clk cycles allowed for one poll transaction.
REQ-003 Parameter STALE_LIMIT, default 3: number of consecutive failed polls that sets data_stale.
REQ-004 clk  in  1  single system clock; all logic is on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 x, y  in  10 each  current raster pixel position.
REQ-007 poll_req  out  1  request to the controller serial poller; held high until poll_done or timeout.
REQ-008 poll_done  in  1  one-cycle pulse from the poller; poll_data is valid in the same cycle.
REQ-009 poll_data  in  64  raw controller response; byte0 = poll_data[63:56], ..., byte7 = poll_data[7:0].
REQ-010 A, B, X, Y, start_pause, L, R, Z, D_UP, D_DOWN, D_RIGHT, D_LEFT  out  1 each  registered button states.
REQ-011 JOY_X, JOY_Y, C_STICK_X, C_STICK_Y, L_TRIGGER, R_TRIGGER  out  8 each  registered analog values.
REQ-012 data_stale  out  1  high while STALE_LIMIT or more consecutive polls have failed.
REQ-013 update_strobe  out  1  one-cycle pulse in the cycle after the outputs change.

Function
REQ-014 The poll trigger shall be the cycle where x == 0 and y == VBLANK_LINE.
REQ-015 The FSM shall have three states: IDLE, POLL and PEND.
REQ-016 In IDLE, a trigger shall move the FSM to POLL and clear the timeout counter; poll_req shall be high exactly while in POLL.
REQ-017 In POLL, poll_done shall capture poll_data into a 64-bit shadow register.
REQ-018 A frame shall be valid when byte0[7:5] == 3'b000 and byte1[7] == 1.
REQ-019 A valid frame shall move the FSM to PEND. An invalid frame shall count as a miss and return the FSM to IDLE.
REQ-020 The timeout counter shall be 16 bits wide and saturating. When it reaches TIMEOUT_CYCLES-1 without poll_done, the poll shall count as a miss and the FSM shall return to IDLE.
REQ-021 If poll_done and the timeout occur in the same cycle, poll_done shall win.
REQ-022 In PEND, the outputs shall be committed in the first cycle with y >= VBLANK_LINE, so outputs never change during active video.
REQ-023 After a commit, the FSM shall enter IDLE, or POLL if that cycle is also a trigger.
REQ-024 Commit mapping from the shadow register:
- start_pause = byte0[4], Y = byte0[3], X = byte0[2], B = byte0[1], A = byte0[0].
- L = byte1[6], R = byte1[5], Z = byte1[4], D_UP = byte1[3], D_DOWN = byte1[2], D_RIGHT = byte1[1], D_LEFT = byte1[0].
- JOY_X = byte2, JOY_Y = byte3, C_STICK_X = byte4, C_STICK_Y = byte5, L_TRIGGER = byte6, R_TRIGGER = byte7.
REQ-025 A trigger arriving in POLL or PEND shall be ignored; the poll is skipped and no miss is counted.
REQ-026 poll_done arriving in IDLE or PEND shall be ignored.
REQ-027 The miss counter shall be 2 bits wide and saturate at STALE_LIMIT.
REQ-028 data_stale shall be set when the miss counter reaches STALE_LIMIT.
REQ-029 Each commit shall clear both the miss counter and data_stale.
REQ-030 update_strobe shall pulse once per commit.

Reset
REQ-031 Reset shall put the FSM in IDLE with poll_req = 0 in the cycle after reset is sampled, including during POLL or PEND; shadow data shall be discarded.
REQ-032 Output reset values:
- all buttons 0;
- JOY_X, JOY_Y, C_STICK_X, C_STICK_Y = 8'h80;
- L_TRIGGER, R_TRIGGER = 8'h00;
- data_stale = 1, update_strobe = 0;
- miss counter and timeout counter = 0.
REQ-033 Reset shall have priority over every other event.

Configuration
REQ-034 Macro INPUT_NEUTRAL_ON_STALE_EN, when defined: while data_stale = 1, all button and analog outputs shall read their reset-neutral values (REQ-032); the last good data is retained internally and reappears at the next commit.
REQ-035 Without INPUT_NEUTRAL_ON_STALE_EN: while data_stale = 1, outputs shall hold the last committed values.

Verification
REQ-036 Reset, then trigger at (0,480); poll_done 10 cycles later with poll_data = 64'h1F80_FF00_8080_40C0 -> A=B=X=Y=start_pause=1, JOY_X=8'hFF, JOY_Y=8'h00, L_TRIGGER=8'h40, R_TRIGGER=8'hC0, data_stale=0, one update_strobe.
REQ-037 Trigger; poll_done arrives while y=100 -> outputs unchanged until the first cycle with y=480, then committed with one strobe.
REQ-038 Three triggers with no poll_done -> poll_req drops after exactly TIMEOUT_CYCLES cycles each time, and data_stale rises after the third timeout; with INPUT_NEUTRAL_ON_STALE_EN the sticks read 8'h80.
REQ-039 poll_data with byte1[7] = 0 -> no commit, miss counter increments, poll_req low the next cycle.
REQ-040 Reset asserted mid-POLL; poll_done arrives one cycle later -> poll_req = 0, outputs at reset values, no strobe.
REQ-041 poll_done in the same cycle as the timeout -> data accepted and no miss counted.

Source files
------------

// File: rtl/input_poll_scheduler.sv
// input_poll_scheduler
// Polls a game controller once per frame, starting at the first vertical-blank
// line. A valid response is held in a shadow register and committed to the
// registered button/analog outputs only during vertical blank, so the outputs
// never change while active video is being drawn. Consecutive failed polls
// (invalid frame or timeout) are counted, and enough of them raise data_stale.
//
// Optional feature: define INPUT_NEUTRAL_ON_STALE_EN to make the outputs read
// neutral values while data_stale is high. Without it, the outputs hold the
// last committed values. In both builds the last good data is kept internally.
module input_poll_scheduler #(
    parameter int VBLANK_LINE    = 480,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int STALE_LIMIT    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    output logic        poll_req,
    input  logic        poll_done,
    input  logic [63:0] poll_data,
    output logic        A,
    output logic        B,
    output logic        X,
    output logic        Y,
    output logic        start_pause,
    output logic        L,
    output logic        R,
    output logic        Z,
    output logic        D_UP,
    output logic        D_DOWN,
    output logic        D_RIGHT,
    output logic        D_LEFT,
    output logic [7:0]  JOY_X,
    output logic [7:0]  JOY_Y,
    output logic [7:0]  C_STICK_X,
    output logic [7:0]  C_STICK_Y,
    output logic [7:0]  L_TRIGGER,
    output logic [7:0]  R_TRIGGER,
    output logic        data_stale,
    output logic        update_strobe
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_POLL,
        ST_PEND
    } state_t;

    // Field order matches the frame bit order once the validity bits
    // (byte0[7:5] and byte1[7]) are removed, so a commit is a plain slice.
    typedef struct packed {
        logic       btn_start;
        logic       btn_y;
        logic       btn_x;
        logic       btn_b;
        logic       btn_a;
        logic       btn_l;
        logic       btn_r;
        logic       btn_z;
        logic       dpad_up;
        logic       dpad_down;
        logic       dpad_right;
        logic       dpad_left;
        logic [7:0] joy_x;
        logic [7:0] joy_y;
        logic [7:0] cstick_x;
        logic [7:0] cstick_y;
        logic [7:0] trig_l;
        logic [7:0] trig_r;
    } pad_t;

    // Buttons released, sticks centred, triggers released.
    localparam pad_t PAD_NEUTRAL = {12'h000, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h00};

    localparam logic [9:0]  VBLANK_Y     = 10'(VBLANK_LINE);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_MAX  = 16'hFFFF;
    localparam logic [1:0]  MISS_SAT     = 2'(STALE_LIMIT);

    state_t      r_state;
    logic        r_poll_req;
    logic [15:0] r_timeout;
    logic [63:0] r_shadow;
    pad_t        r_pad;
    logic [1:0]  r_miss;
    logic        r_stale;
    logic        r_strobe;

    logic        w_trigger;
    logic        w_in_vblank;
    logic        w_frame_valid;
    logic        w_timeout_hit;
    logic [1:0]  w_miss_next;
    pad_t        w_shadow_pad;
    pad_t        w_pad_view;
    logic        w_unused_shadow;

    // Poll decode and the saturated value the miss counter takes on a failure.
    assign w_trigger     = (x == 10'd0) && (y == VBLANK_Y);
    assign w_in_vblank   = (y >= VBLANK_Y);
    assign w_frame_valid = (poll_data[63:61] == 3'b000) && poll_data[55];
    assign w_timeout_hit = (r_timeout == TIMEOUT_LAST);
    assign w_miss_next   = (r_miss == MISS_SAT) ? r_miss : r_miss + 2'd1;
    assign w_shadow_pad  = {r_shadow[60:56], r_shadow[54:0]};

    // The validity bits were already checked when the frame was captured.
    assign w_unused_shadow = ^{r_shadow[63:61], r_shadow[55]};

    // Poll FSM, miss tracking and output commit, all with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: reset wins over every other event, so it is the outermost branch.
            r_state    <= ST_IDLE;
            r_poll_req <= 1'b0;
            r_timeout  <= 16'd0;
            // NOTE: the shadow register is reset on purpose so a poll in flight
            // at reset can never leak stale data into a later commit.
            r_shadow   <= 64'd0;
            r_pad      <= PAD_NEUTRAL;
            r_miss     <= 2'd0;
            r_stale    <= 1'b1;
            r_strobe   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments everywhere here; the defaults below
            // are overridden later in the same block only where an event occurs.
            r_strobe <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        r_state    <= ST_POLL;
                        r_poll_req <= 1'b1;
                        r_timeout  <= 16'd0;
                    end
                end
                ST_POLL: begin
                    // poll_done is tested first so it wins over a same-cycle timeout.
                    if (poll_done) begin
                        r_shadow   <= poll_data;
                        r_poll_req <= 1'b0;
                        if (w_frame_valid) begin
                            r_state <= ST_PEND;
                        end else begin
                            r_state <= ST_IDLE;
                            r_miss  <= w_miss_next;
                            if (w_miss_next == MISS_SAT) r_stale <= 1'b1;
                        end
                    end else if (w_timeout_hit) begin
                        r_state    <= ST_IDLE;
                        r_poll_req <= 1'b0;
                        r_miss     <= w_miss_next;
                        if (w_miss_next == MISS_SAT) r_stale <= 1'b1;
                    end else if (r_timeout != TIMEOUT_MAX) begin
                        r_timeout <= r_timeout + 16'd1;
                    end
                end
                ST_PEND: begin
                    // Hold the new frame until vertical blank so active video
                    // always sees one consistent controller state.
                    if (w_in_vblank) begin
                        r_pad    <= w_shadow_pad;
                        r_miss   <= 2'd0;
                        r_stale  <= 1'b0;
                        r_strobe <= 1'b1;
                        if (w_trigger) begin
                            r_state    <= ST_POLL;
                            r_poll_req <= 1'b1;
                            r_timeout  <= 16'd0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_poll_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef INPUT_NEUTRAL_ON_STALE_EN
    // Stale data is masked to neutral; r_pad keeps the last good frame.
    assign w_pad_view = r_stale ? PAD_NEUTRAL : r_pad;
`else
    // Stale data simply keeps showing the last committed frame.
    assign w_pad_view = r_pad;
`endif

    assign poll_req      = r_poll_req;
    assign data_stale    = r_stale;
    assign update_strobe = r_strobe;

    assign start_pause = w_pad_view.btn_start;
    assign Y           = w_pad_view.btn_y;
    assign X           = w_pad_view.btn_x;
    assign B           = w_pad_view.btn_b;
    assign A           = w_pad_view.btn_a;
    assign L           = w_pad_view.btn_l;
    assign R           = w_pad_view.btn_r;
    assign Z           = w_pad_view.btn_z;
    assign D_UP        = w_pad_view.dpad_up;
    assign D_DOWN      = w_pad_view.dpad_down;
    assign D_RIGHT     = w_pad_view.dpad_right;
    assign D_LEFT      = w_pad_view.dpad_left;
    assign JOY_X       = w_pad_view.joy_x;
    assign JOY_Y       = w_pad_view.joy_y;
    assign C_STICK_X   = w_pad_view.cstick_x;
    assign C_STICK_Y   = w_pad_view.cstick_y;
    assign L_TRIGGER   = w_pad_view.trig_l;
    assign R_TRIGGER   = w_pad_view.trig_r;

endmodule

// File: tb/tb_input_poll_scheduler.sv
// Testbench for input_poll_scheduler: randomized polls checked against a
// frame-level reference model (decoded pad, miss count, stale flag).
module tb_input_poll_scheduler;

    localparam int VBL   = 480;
    localparam int TOUT  = 200;
    localparam int LIMIT = 3;

    typedef struct packed {
        logic a, b, xb, yb, st, l, r, z, up, dn, rt, lf;
        logic [7:0] jx, jy, cx, cy, lt, rtg;
    } pad_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic        poll_req;
    logic        poll_done = 1'b0;
    logic [63:0] poll_data = '0;
    logic        A, B, X, Y, start_pause, L, R, Z, D_UP, D_DOWN, D_RIGHT, D_LEFT;
    logic [7:0]  JOY_X, JOY_Y, C_STICK_X, C_STICK_Y, L_TRIGGER, R_TRIGGER;
    logic        data_stale, update_strobe;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   strobe_seen = 0;

    pad_t m_pad;
    int   m_miss;
    bit   m_stale;

    input_poll_scheduler #(
        .VBLANK_LINE(VBL), .TIMEOUT_CYCLES(TOUT), .STALE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset(reset), .x(x), .y(y),
        .poll_req(poll_req), .poll_done(poll_done), .poll_data(poll_data),
        .A(A), .B(B), .X(X), .Y(Y), .start_pause(start_pause),
        .L(L), .R(R), .Z(Z), .D_UP(D_UP), .D_DOWN(D_DOWN),
        .D_RIGHT(D_RIGHT), .D_LEFT(D_LEFT),
        .JOY_X(JOY_X), .JOY_Y(JOY_Y), .C_STICK_X(C_STICK_X), .C_STICK_Y(C_STICK_Y),
        .L_TRIGGER(L_TRIGGER), .R_TRIGGER(R_TRIGGER),
        .data_stale(data_stale), .update_strobe(update_strobe)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic pad_t neutral_pad();
        pad_t p;
        p = '0;
        p.jx = 8'h80; p.jy = 8'h80; p.cx = 8'h80; p.cy = 8'h80;
        return p;
    endfunction

    function automatic pad_t model_decode(input logic [63:0] f);
        pad_t p;
        logic [7:0] bt [8];
        for (int i = 0; i < 8; i++) bt[i] = f[63 - 8*i -: 8];
        p.st = bt[0][4]; p.yb = bt[0][3]; p.xb = bt[0][2]; p.b = bt[0][1]; p.a = bt[0][0];
        p.l  = bt[1][6]; p.r  = bt[1][5]; p.z  = bt[1][4]; p.up = bt[1][3];
        p.dn = bt[1][2]; p.rt = bt[1][1]; p.lf = bt[1][0];
        p.jx = bt[2]; p.jy = bt[3]; p.cx = bt[4]; p.cy = bt[5]; p.lt = bt[6]; p.rtg = bt[7];
        return p;
    endfunction

    function automatic logic [63:0] gen_frame(input bit valid);
        logic [63:0] f;
        f = {$urandom, $urandom};
        if (valid) begin
            f[63:61] = 3'b000;
            f[55]    = 1'b1;
        end else if ($urandom_range(0, 1) == 1) begin
            f[55] = 1'b0;
        end else begin
            f[63:61] = 3'($urandom_range(1, 7));
        end
        return f;
    endfunction

    function automatic pad_t m_view();
`ifdef INPUT_NEUTRAL_ON_STALE_EN
        return m_stale ? neutral_pad() : m_pad;
`else
        return m_pad;
`endif
    endfunction

    function automatic pad_t dut_pad();
        pad_t p;
        p.a = A; p.b = B; p.xb = X; p.yb = Y; p.st = start_pause;
        p.l = L; p.r = R; p.z = Z; p.up = D_UP; p.dn = D_DOWN; p.rt = D_RIGHT; p.lf = D_LEFT;
        p.jx = JOY_X; p.jy = JOY_Y; p.cx = C_STICK_X; p.cy = C_STICK_Y;
        p.lt = L_TRIGGER; p.rtg = R_TRIGGER;
        return p;
    endfunction

    task automatic model_reset();
        m_pad = neutral_pad(); m_miss = 0; m_stale = 1'b1;
    endtask

    task automatic model_commit(input logic [63:0] f);
        m_pad = model_decode(f); m_miss = 0; m_stale = 1'b0;
    endtask

    task automatic model_miss();
        if (m_miss < LIMIT) m_miss++;
        if (m_miss >= LIMIT) m_stale = 1'b1;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        if (update_strobe === 1'b1) strobe_seen++;
    endtask

    task automatic do_trigger();
        x = 10'd0; y = 10'(VBL);
        step();
        x = 10'd1;
    endtask

    task automatic poll_frame(input logic [63:0] f);
        do_trigger();
        repeat (3) step();
        x = 10'd3; y = 10'(VBL); poll_done = 1'b1; poll_data = f;
        step();
        poll_done = 1'b0;
        repeat (3) step();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; poll_done = 1'b0; x = 10'd1; y = 10'd0;
        step(); step();
        reset = 1'b0;
        model_reset();
        strobe_seen = 0;
        step();
        n_tests++;
        if (poll_req !== 1'b0) begin n_fail++; $display("FAIL reset_poll_req: got %b exp 0", poll_req); end
        n_tests++;
        if (data_stale !== 1'b1) begin n_fail++; $display("FAIL reset_stale: got %b exp 1", data_stale); end
        n_tests++;
        if (dut_pad() !== neutral_pad()) begin n_fail++; $display("FAIL reset_pad: got %h exp %h", dut_pad(), neutral_pad()); end
        step(); step();
        n_tests++;
        if (strobe_seen !== 0) begin n_fail++; $display("FAIL reset_strobe: got %0d exp 0", strobe_seen); end
    endtask

    task automatic test_basic();
        logic [63:0] f;
        f = 64'h1F80_FF00_8080_40C0;
        strobe_seen = 0;
        do_trigger();
        n_tests++;
        if (poll_req !== 1'b1) begin n_fail++; $display("FAIL basic_req_high: got %b exp 1", poll_req); end
        x = 10'd5;
        repeat (9) step();
        poll_done = 1'b1; poll_data = f;
        step();
        poll_done = 1'b0;
        n_tests++;
        if (poll_req !== 1'b0) begin n_fail++; $display("FAIL basic_req_low: got %b exp 0", poll_req); end
        repeat (3) step();
        model_commit(f);
        n_tests++;
        if (strobe_seen !== 1) begin n_fail++; $display("FAIL basic_strobes: got %0d exp 1", strobe_seen); end
        n_tests++;
        if (dut_pad() !== m_view()) begin n_fail++; $display("FAIL basic_pad: got %h exp %h", dut_pad(), m_view()); end
        n_tests++;
        if ({A, B, X, Y, start_pause} !== 5'b11111 || JOY_X !== 8'hFF || JOY_Y !== 8'h00 ||
            L_TRIGGER !== 8'h40 || R_TRIGGER !== 8'hC0)
        begin
            n_fail++;
            $display("FAIL basic_fields: got btn=%b jx=%h jy=%h lt=%h rt=%h exp btn=11111 jx=ff jy=00 lt=40 rt=c0",
                     {A, B, X, Y, start_pause}, JOY_X, JOY_Y, L_TRIGGER, R_TRIGGER);
        end
        n_tests++;
        if (data_stale !== 1'b0) begin n_fail++; $display("FAIL basic_stale: got %b exp 0", data_stale); end
    endtask

    task automatic test_defer();
        logic [63:0] f;
        f = gen_frame(1'b1);
        strobe_seen = 0;
        do_trigger();
        y = 10'd100;
        repeat (3) step();
        poll_done = 1'b1; poll_data = f;
        step();
        poll_done = 1'b0;
        repeat (6) step();
        n_tests++;
        if (strobe_seen !== 0) begin n_fail++; $display("FAIL defer_early_strobe: got %0d exp 0", strobe_seen); end
        n_tests++;
        if (dut_pad() !== m_view()) begin n_fail++; $display("FAIL defer_held: got %h exp %h", dut_pad(), m_view()); end
        x = 10'd7; y = 10'(VBL);
        step(); step();
        model_commit(f);
        n_tests++;
        if (strobe_seen !== 1) begin n_fail++; $display("FAIL defer_strobe: got %0d exp 1", strobe_seen); end
        n_tests++;
        if (dut_pad() !== m_view()) begin n_fail++; $display("FAIL defer_pad: got %h exp %h", dut_pad(), m_view()); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] f1, f2;
        f1 = gen_frame(1'b1);
        f2 = gen_frame(1'b1);
        strobe_seen = 0;
        do_trigger();
        y = 10'd100;
        repeat (2) step();
        poll_done = 1'b1; poll_data = f1;
        step();
        poll_done = 1'b0;
        repeat (2) step();
        // Commit cycle coincides with the next trigger.
        x = 10'd0; y = 10'(VBL);
        step();
        x = 10'd1;
        model_commit(f1);
        n_tests++;
        if (poll_req !== 1'b1 || strobe_seen !== 1) begin
            n_fail++;
            $display("FAIL b2b_commit_trigger: got req=%b strobes=%0d exp req=1 strobes=1", poll_req, strobe_seen);
        end
        n_tests++;
        if (dut_pad() !== m_view()) begin n_fail++; $display("FAIL b2b_pad1: got %h exp %h", dut_pad(), m_view()); end
        repeat (3) step();
        poll_done = 1'b1; poll_data = f2;
        step();
        poll_done = 1'b0;
        repeat (2) step();
        model_commit(f2);
        n_tests++;
        if (strobe_seen !== 2 || dut_pad() !== m_view()) begin
            n_fail++;
            $display("FAIL b2b_pad2: got strobes=%0d pad=%h exp strobes=2 pad=%h", strobe_seen, dut_pad(), m_view());
        end
    endtask

    task automatic test_timeout();
        int cnt;
        strobe_seen = 0;
        for (int k = 0; k < 3; k++) begin
            do_trigger();
            cnt = 0;
            while (poll_req === 1'b1 && cnt < TOUT + 20) begin
                step();
                cnt++;
            end
            model_miss();
            n_tests++;
            if (cnt !== TOUT) begin n_fail++; $display("FAIL timeout_len%0d: got %0d exp %0d", k, cnt, TOUT); end
            step();
            n_tests++;
            if (data_stale !== m_stale) begin n_fail++; $display("FAIL timeout_stale%0d: got %b exp %b", k, data_stale, m_stale); end
            n_tests++;
            if (dut_pad() !== m_view()) begin n_fail++; $display("FAIL timeout_pad%0d: got %h exp %h", k, dut_pad(), m_view()); end
        end
        n_tests++;
        if (data_stale !== 1'b1 || strobe_seen !== 0) begin
            n_fail++;
            $display("FAIL timeout_final: got stale=%b strobes=%0d exp stale=1 strobes=0", data_stale, strobe_seen);
        end
`ifdef INPUT_NEUTRAL_ON_STALE_EN
        n_tests++;
        if (JOY_X !== 8'h80 || JOY_Y !== 8'h80 || C_STICK_X !== 8'h80 || C_STICK_Y !== 8'h80) begin
            n_fail++;
            $display("FAIL timeout_neutral: got %h %h %h %h exp 80 80 80 80", JOY_X, JOY_Y, C_STICK_X, C_STICK_Y);
        end
`endif
    endtask

    task automatic test_invalid();
        logic [63:0] f;
        f = gen_frame(1'b1);
        poll_frame(f);
        model_commit(f);
        for (int k = 0; k < 3; k++) begin
            f = gen_frame(1'b0);
            strobe_seen = 0;
            do_trigger();
            repeat (4) step();
            poll_done = 1'b1; poll_data = f;
            step();
            poll_done = 1'b0;
            model_miss();
            n_tests++;
            if (poll_req !== 1'b0) begin n_fail++; $display("FAIL invalid_req%0d: got %b exp 0", k, poll_req); end
            repeat (2) step();
            n_tests++;
            if (strobe_seen !== 0 || data_stale !== m_stale || dut_pad() !== m_view()) begin
                n_fail++;
                $display("FAIL invalid_state%0d: got strobes=%0d stale=%b pad=%h exp strobes=0 stale=%b pad=%h",
                         k, strobe_seen, data_stale, dut_pad(), m_stale, m_view());
            end
        end
    endtask

    task automatic test_done_at_timeout();
        logic [63:0] f;
        f = gen_frame(1'b1);
        strobe_seen = 0;
        do_trigger();
        repeat (TOUT - 1) step();
        poll_done = 1'b1; poll_data = f;
        step();
        poll_done = 1'b0;
        n_tests++;
        if (poll_req !== 1'b0) begin n_fail++; $display("FAIL edge_req: got %b exp 0", poll_req); end
        repeat (2) step();
        model_commit(f);
        n_tests++;
        if (strobe_seen !== 1 || data_stale !== 1'b0 || dut_pad() !== m_view()) begin
            n_fail++;
            $display("FAIL edge_accept: got strobes=%0d stale=%b pad=%h exp strobes=1 stale=0 pad=%h",
                     strobe_seen, data_stale, dut_pad(), m_view());
        end
    endtask

    task automatic test_reset_mid_poll();
        logic [63:0] f;
        f = gen_frame(1'b1);
        poll_frame(f);
        model_commit(f);
        strobe_seen = 0;
        do_trigger();
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
        n_tests++;
        if (poll_req !== 1'b0) begin n_fail++; $display("FAIL rstpoll_req: got %b exp 0", poll_req); end
        poll_done = 1'b1; poll_data = gen_frame(1'b1);
        step();
        poll_done = 1'b0;
        repeat (3) step();
        n_tests++;
        if (strobe_seen !== 0 || poll_req !== 1'b0 || data_stale !== 1'b1 || dut_pad() !== m_view()) begin
            n_fail++;
            $display("FAIL rstpoll_state: got strobes=%0d req=%b stale=%b pad=%h exp strobes=0 req=0 stale=1 pad=%h",
                     strobe_seen, poll_req, data_stale, dut_pad(), m_view());
        end
    endtask

    task automatic test_random();
        logic [63:0] f;
        int cnt, d, spur_k, exp_strobe;
        bit valid, do_spur;
        logic [9:0] yd;
        for (int it = 0; it < 24; it++) begin
            strobe_seen = 0;
            exp_strobe = 0;
            if ($urandom_range(0, 3) == 0) begin
                // poll_done while idle must be ignored
                x = 10'd9; y = 10'($urandom_range(0, 524));
                poll_done = 1'b1; poll_data = gen_frame(1'b1);
                step();
                poll_done = 1'b0;
            end
            valid = ($urandom_range(0, 2) != 0);
            f = gen_frame(valid);
            do_trigger();
            if ($urandom_range(0, 9) == 0) begin
                cnt = 0;
                while (poll_req === 1'b1 && cnt < TOUT + 20) begin
                    step();
                    cnt++;
                end
                model_miss();
                n_tests++;
                if (cnt !== TOUT) begin n_fail++; $display("FAIL rand%0d_timeout: got %0d exp %0d", it, cnt, TOUT); end
                step();
            end else begin
                d = $urandom_range(0, 30);
                yd = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(VBL, 524)) : 10'($urandom_range(0, VBL - 1));
                spur_k = $urandom_range(0, 30);
                do_spur = ($urandom_range(0, 1) == 1);
                for (int i = 0; i < d; i++) begin
                    if (do_spur && i == spur_k) begin
                        x = 10'd0; y = 10'(VBL);
                    end else begin
                        x = 10'(1 + i); y = yd;
                    end
                    step();
                end
                x = 10'd3; y = yd; poll_done = 1'b1; poll_data = f;
                step();
                poll_done = 1'b0;
                n_tests++;
                if (poll_req !== 1'b0) begin n_fail++; $display("FAIL rand%0d_req: got %b exp 0", it, poll_req); end
                if (valid) begin
                    if (yd < 10'(VBL)) begin
                        step(); step();
                        n_tests++;
                        if (strobe_seen !== 0 || dut_pad() !== m_view()) begin
                            n_fail++;
                            $display("FAIL rand%0d_hold: got strobes=%0d pad=%h exp strobes=0 pad=%h",
                                     it, strobe_seen, dut_pad(), m_view());
                        end
                        x = 10'd4; y = 10'($urandom_range(VBL, 524));
                    end
                    step(); step();
                    model_commit(f);
                    exp_strobe = 1;
                end else begin
                    model_miss();
                    step(); step();
                end
            end
            n_tests++;
            if (strobe_seen !== exp_strobe || data_stale !== m_stale || dut_pad() !== m_view() || poll_req !== 1'b0) begin
                n_fail++;
                $display("FAIL rand%0d_state: got strobes=%0d stale=%b req=%b pad=%h exp strobes=%0d stale=%b req=0 pad=%h",
                         it, strobe_seen, data_stale, poll_req, dut_pad(), exp_strobe, m_stale, m_view());
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_defer();
        test_back_to_back();
        test_timeout();
        test_invalid();
        test_done_at_timeout();
        test_reset_mid_poll();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
